// File: rtl/cache_fill_responder_if.sv
// Fill handshake, SDRAM read port and write-snoop bundle for cache_fill_responder.
// The slave modport is the responder's view; master is the cache/controller side.
interface cache_fill_responder_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16
) ();
  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_strobe;
  logic [DATA_W-1:0] fill_data;
  logic              mem_req;
  logic [ADDR_W-2:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              snoop_we;
  logic [ADDR_W-1:0] snoop_addr;

  modport slave (
    input  fill_req, fill_addr, mem_ack, mem_rvalid, mem_rdata, snoop_we, snoop_addr,
    output fill_strobe, fill_data, mem_req, mem_addr
  );

  modport master (
    output fill_req, fill_addr, mem_ack, mem_rvalid, mem_rdata, snoop_we, snoop_addr,
    input  fill_strobe, fill_data, mem_req, mem_addr
  );
endinterface

// File: rtl/cache_fill_responder.sv
// Fetches a 4-word line from SDRAM and streams it critical-word-first to the cache.
// Optional macro LINE_REUSE_EN keeps the last streamed line for snoop-guarded reuse.
module cache_fill_responder #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  cache_fill_responder_if.slave bus
);
  localparam int LINE_W = ADDR_W - 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_COLLECT,
    S_STREAM,
    S_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        crit_q, crit_d;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-2:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic              fill_strobe_q, fill_strobe_d;
  logic [DATA_W-1:0] line_buf_q [4];
  logic              buf_we;
  logic [LINE_W-1:0] req_line;
  logic [LINE_W-1:0] held_line;
  logic [1:0]        rd_idx;
  logic              hit;
  logic              unused_addr_lsb;

  assign req_line        = bus.fill_addr[ADDR_W-1:3];
  assign held_line       = mem_addr_q[ADDR_W-2:2];
  assign rd_idx          = crit_q + idx_q;
  assign unused_addr_lsb = bus.fill_addr[0];

`ifdef LINE_REUSE_EN
  logic       valid_q, valid_d;
  logic       snooped_q, snooped_d;
  logic       snoop_hit;
  logic [2:0] unused_snoop_lsb;

  // mem_addr_q doubles as the tag of the buffered line.
  assign snoop_hit        = bus.snoop_we && (bus.snoop_addr[ADDR_W-1:3] == held_line);
  assign hit              = valid_q && (req_line == held_line) && !snoop_hit;
  assign unused_snoop_lsb = bus.snoop_addr[2:0];
`else
  logic unused_snoop;

  assign hit          = 1'b0;
  assign unused_snoop = ^{bus.snoop_we, bus.snoop_addr};
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    crit_d        = crit_q;
    drop_d        = drop_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    fill_data_d   = fill_data_q;
    fill_strobe_d = 1'b0;
    buf_we        = 1'b0;
`ifdef LINE_REUSE_EN
    valid_d   = valid_q && !snoop_hit;
    snooped_d = snooped_q ||
                (snoop_hit && (state_q inside {S_ISSUE, S_COLLECT, S_STREAM}));
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.fill_req) begin
          crit_d = bus.fill_addr[2:1];
          idx_d  = 2'd0;
`ifdef LINE_REUSE_EN
          snooped_d = 1'b0;
`endif
          if (hit) begin
            state_d = S_STREAM;
          end else begin
            state_d    = S_ISSUE;
            mem_req_d  = 1'b1;
            mem_addr_d = {req_line, 2'b00};
            cnt_d      = 2'd0;
            drop_d     = 1'b0;
`ifdef LINE_REUSE_EN
            valid_d = 1'b0;
`endif
          end
        end
      end

      S_ISSUE: begin
        if (!bus.fill_req) drop_d = 1'b1;
        if (mem_req_q && bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (!bus.fill_req) drop_d = 1'b1;
        if (bus.mem_rvalid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (drop_q || !bus.fill_req) begin
              state_d = S_RELEASE;
            end else begin
              // Emit the critical word now so the stream starts right after the last beat.
              state_d       = S_STREAM;
              fill_data_d   = (crit_q == 2'd3) ? bus.mem_rdata : line_buf_q[crit_q];
              fill_strobe_d = 1'b1;
              idx_d         = 2'd1;
            end
          end
        end
      end

      S_STREAM: begin
        fill_data_d   = line_buf_q[rd_idx];
        fill_strobe_d = (idx_q == 2'd0);
        idx_d         = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_RELEASE;
`ifdef LINE_REUSE_EN
          valid_d = !(snooped_q || snoop_hit);
`endif
        end
      end

      S_RELEASE: begin
        if (!bus.fill_req) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state and outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 2'd0;
      idx_q         <= 2'd0;
      drop_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      fill_data_q   <= '0;
      fill_strobe_q <= 1'b0;
`ifdef LINE_REUSE_EN
      valid_q   <= 1'b0;
      snooped_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      drop_q        <= drop_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      fill_data_q   <= fill_data_d;
      fill_strobe_q <= fill_strobe_d;
`ifdef LINE_REUSE_EN
      valid_q   <= valid_d;
      snooped_q <= snooped_d;
`endif
    end
  end

  // Line buffer and critical index
  always_ff @(posedge clk) begin
    crit_q <= crit_d;
    if (buf_we) line_buf_q[cnt_q] <= bus.mem_rdata;
  end

  assign bus.fill_strobe = fill_strobe_q;
  assign bus.fill_data   = fill_data_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
endmodule

// File: tb/tb_cache_fill_responder.sv
// Scoreboard bench for cache_fill_responder: directed fills, reset/abort cases, random fills.
// Expectations come from a line-level model; define LINE_REUSE_EN to also model line reuse.
module tb_cache_fill_responder;
  localparam int AW  = 26;
  localparam int DW  = 16;
  localparam int WAW = AW - 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cache_fill_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cache_fill_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [3:0][DW-1:0] w;
    bit                 hit;
    int                 req_cyc;
  } exp_t;

  exp_t             exp_q[$];
  logic [WAW-1:0]   exp_addr_q[$];
  logic [DW-1:0]    mem_img [logic [WAW-1:0]];
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               last_rv_cyc = 0;
  int               streams_done = 0;
  int               words_sent = 0;
  int               gap_min = 0;
  int               gap_max = 0;
  int               ack_max = 0;
  bit               mem_busy = 1'b0;
  bit               m_valid = 1'b0;
  logic [AW-4:0]    m_tag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [WAW-1:0] wa);
    if (mem_img.exists(wa)) return mem_img[wa];
    return DW'(wa * 25'd40503) ^ 16'h5A5A;
  endfunction

  // SDRAM controller model: acks after a random delay, returns the line with random gaps.
  initial begin
    logic [WAW-1:0] base;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      tick();
      if (bus.mem_req === 1'b1 && reset_n === 1'b1) begin
        mem_busy   = 1'b1;
        words_sent = 0;
        if (exp_addr_q.size() == 0) check("mem_req_unexpected", 32'(bus.mem_req), 32'd0);
        else check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr_q.pop_front()));
        base = bus.mem_addr;
        repeat ($urandom_range(ack_max, 0)) begin
          tick();
          check("mem_req_held", 32'(bus.mem_req), 32'd1);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("mem_req_drop", 32'(bus.mem_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
          repeat ($urandom_range(gap_max, gap_min)) tick();
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_word(base + WAW'(k));
          words_sent++;
          last_rv_cyc = cyc;
          tick();
          bus.mem_rvalid = 1'b0;
        end
        mem_busy = 1'b0;
      end
    end
  end

  // Monitor: every strobe pops one expected line and checks the four consecutive words.
  initial begin
    exp_t e;
    forever begin
      tick();
      if (bus.fill_strobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("strobe_unexpected", 32'(bus.fill_strobe), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_time", 32'(cyc), 32'(e.hit ? e.req_cyc + 2 : last_rv_cyc + 1));
          check("word0", 32'(bus.fill_data), 32'(e.w[0]));
          for (int i = 1; i < 4; i++) begin
            tick();
            check("word_n", 32'(bus.fill_data), 32'(e.w[i]));
            check("strobe_low", 32'(bus.fill_strobe), 32'd0);
          end
          streams_done++;
        end
      end
    end
  end

  task automatic snoop(input logic [AW-1:0] a);
    bus.snoop_we   = 1'b1;
    bus.snoop_addr = a;
    tick();
    bus.snoop_we = 1'b0;
    if (m_valid && a[AW-1:3] == m_tag) m_valid = 1'b0;
  endtask

  // mode 0: normal fill, 1: drop fill_req during COLLECT, 2: reset during COLLECT
  task automatic do_fill(input logic [AW-1:0] a, input int hold, input int mode);
    logic [AW-4:0] line;
    logic [1:0]    crit;
    bit            hit;
    exp_t          e;
    int            n;
    line = a[AW-1:3];
    crit = a[2:1];
    hit  = 1'b0;
`ifdef LINE_REUSE_EN
    hit = m_valid && (m_tag == line);
`endif
    for (int k = 0; k < 400 && mem_busy; k++) tick();
    if (!hit) exp_addr_q.push_back({line, 2'b00});
    n = streams_done;
    bus.fill_addr = a;
    bus.fill_req  = 1'b1;
    if (mode == 0) begin
      for (int i = 0; i < 4; i++) e.w[i] = mem_word({line, 2'b00} + WAW'((int'(crit) + i) % 4));
      e.hit     = hit;
      e.req_cyc = cyc;
      exp_q.push_back(e);
      for (int k = 0; k < 400 && streams_done == n; k++) tick();
      check("stream_done", 32'(streams_done != n), 32'd1);
      repeat (hold) begin
        tick();
        check("no_rerequest", 32'(bus.mem_req), 32'd0);
      end
      bus.fill_req = 1'b0;
      tick();
      m_valid = 1'b1;
      m_tag   = line;
    end else if (mode == 1) begin
      for (int k = 0; k < 400 && !(mem_busy && words_sent >= 1); k++) tick();
      check("drop_reached", 32'(mem_busy && words_sent >= 1), 32'd1);
      bus.fill_req = 1'b0;
      for (int k = 0; k < 400 && mem_busy; k++) tick();
      repeat (3) begin
        tick();
        check("drop_no_req", 32'(bus.mem_req), 32'd0);
      end
      m_valid = 1'b0;
    end else begin
      for (int k = 0; k < 400 && !(mem_busy && words_sent >= 2); k++) tick();
      check("rst_reached", 32'(mem_busy && words_sent >= 2), 32'd1);
      reset_n      = 1'b0;
      bus.fill_req = 1'b0;
      tick();
      reset_n = 1'b1;
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_fill_data", 32'(bus.fill_data), 32'd0);
      check("rst_strobe", 32'(bus.fill_strobe), 32'd0);
      for (int k = 0; k < 400 && mem_busy; k++) begin
        tick();
        check("rst_stray_req", 32'(bus.mem_req), 32'd0);
      end
      m_valid = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    reset_n        = 1'b0;
    bus.fill_req   = 1'b0;
    bus.fill_addr  = '0;
    bus.snoop_we   = 1'b0;
    bus.snoop_addr = '0;
    repeat (3) tick();
    check("reset_strobe", 32'(bus.fill_strobe), 32'd0);
    check("reset_mem_req", 32'(bus.mem_req), 32'd0);
    check("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset_fill_data", 32'(bus.fill_data), 32'd0);
    reset_n = 1'b1;
    tick();

    mem_img[25'h204] = 16'h1111;
    mem_img[25'h205] = 16'h2222;
    mem_img[25'h206] = 16'h3333;
    mem_img[25'h207] = 16'h4444;

    do_fill(26'h000408, 0, 0);
    gap_min = 2; gap_max = 2;
    do_fill(26'h00040C, 0, 0);
    gap_min = 0; gap_max = 1; ack_max = 2;
    do_fill(26'h000408, 5, 0);
    snoop(26'h00040A);
    do_fill(26'h000408, 0, 0);

    gap_min = 1; gap_max = 2;
    do_fill(26'h3F0010, 0, 2);
    do_fill(26'h3F0012, 0, 0);
    do_fill(26'h3F0020, 0, 1);
    do_fill(26'h3F0024, 1, 0);

    gap_min = 0; ack_max = 3;
    for (int t = 0; t < 24; t++) begin
      gap_max = $urandom_range(3, 0);
      if ($urandom_range(3, 0) == 0) begin
        a = {23'h000100 + 23'($urandom_range(3, 0)), 3'($urandom_range(7, 0))};
        snoop(a);
      end
      a = {23'h000100 + 23'($urandom_range(3, 0)), 3'($urandom_range(7, 0))};
      do_fill(a, $urandom_range(2, 0), 0);
    end

    repeat (10) tick();
    check("exp_stream_empty", 32'(exp_q.size()), 32'd0);
    check("exp_addr_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_fill_responder.md
# cache_fill_responder

SDRAM-side responder for the two-way cache's line-fill handshake. It accepts a level fill request plus byte address from the cache and fetches the 4-word (64-bit) line from the SDRAM controller port, which may return words with gaps. It buffers the line, then streams it back critical-word-first: four contiguous words, with a one-cycle strobe on the first. It sits between the cache's `sdram_req`/`sdram_fill`/`data_from_sdram` pins and the SDRAM controller read port.

## Interface
- `ADDR_W`, 26: byte address width (64 MB).
- `DATA_W`, 16: word width.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; synchronous, active-low.
- `fill_req`  in  1  level request from the cache; held until the strobe is seen.
- `fill_addr`  in  ADDR_W  byte address; `[ADDR_W-1:3]` is the line and `[2:1]` is the critical word.
- `fill_strobe`  out  1  one-cycle pulse marking the first (critical) word on `fill_data`.
- `fill_data`  out  DATA_W  streamed word, registered.
- `mem_req`  out  1  burst read request, held until `mem_ack`.
- `mem_addr`  out  ADDR_W-1  word address of the line base (`{line,2'b00}`).
- `mem_ack`  in  1  controller accepted the request (one cycle).
- `mem_rvalid`  in  1  read word valid.
- `mem_rdata`  in  DATA_W  read word; arrives in linear order, index 0..3.
- `snoop_we`  in  1  write to memory in progress (used only with the macro).
- `snoop_addr`  in  ADDR_W  byte address of that write.

## Operation
- Reset values: `fill_strobe`=0, `mem_req`=0, `mem_addr`=0, `fill_data`=0, state IDLE, word counter 0, line-valid 0.
- IDLE: on `fill_req`=1, latch the line address and the critical index `crit`=`fill_addr[2:1]`, then go to ISSUE.
- ISSUE: `mem_req`=1 and `mem_addr`=line base.
  - On `mem_ack`: drop `mem_req` and go to COLLECT.
  - `mem_ack` is honoured only while `mem_req`=1.
- COLLECT: each `mem_rvalid` writes `buf[cnt]` and increments `cnt` (2-bit).
  - On the 4th word, go to STREAM.
  - If `fill_req` was low at any point since ISSUE, go to RELEASE instead.
  - `mem_rvalid` outside COLLECT is ignored.
- STREAM: a 4-cycle sequence with index `i`=0..3.
  - `fill_data`=`buf[(crit+i) mod 4]` (2-bit wrap).
  - `fill_strobe`=1 only for `i`=0.
  - After `i`=3, go to RELEASE.
- RELEASE: wait until `fill_req`=0 is sampled, then go to IDLE. This prevents a stale level being taken as a new request.
- `fill_data` holds its last value outside STREAM.
- Reset mid-operation: return to IDLE immediately. Later `mem_rvalid`s from the aborted burst are ignored.

## Timing
- `fill_req` sampled high at cycle T → `mem_req`=1 at T+1.
- 4th `mem_rvalid` sampled at cycle R → `fill_strobe`=1 with the critical word at R+1; the remaining words follow at R+2, R+3, R+4 with no gaps (the cache samples on consecutive clocks).
- Minimum miss latency from `fill_req` to strobe is 3 cycles plus controller latency.
- Back-to-back requests: at least one cycle of `fill_req`=0 is required between fills.

## Configuration
- `LINE_REUSE_EN` defined:
  - After a completed STREAM, the line tag is held with valid=1.
  - A request in IDLE whose `fill_addr[ADDR_W-1:3]` matches the held tag while valid=1 goes straight to STREAM. The strobe appears 2 cycles after the request is sampled, with no `mem_req`.
  - `snoop_we` with a matching `snoop_addr[ADDR_W-1:3]` clears valid. If it coincides with the hit check, the invalidate wins and the request is treated as a miss.
  - A matching snoop between ISSUE and the end of STREAM leaves valid=0 after the stream.
- `LINE_REUSE_EN` undefined: no tag storage, every request fetches from memory, and the snoop inputs are ignored.

## Test plan
- Request with `fill_addr`=0x000408 (crit=0); memory returns 0x1111, 0x2222, 0x3333, 0x4444 back-to-back → `mem_addr`=0x000204; `fill_data` runs 0x1111, 0x2222, 0x3333, 0x4444; strobe is high only with 0x1111.
- Same line with `fill_addr`=0x00040C (crit=2) and 2-cycle gaps between `mem_rvalid`s → output is 0x3333, 0x4444, 0x1111, 0x2222 on 4 consecutive cycles, starting one cycle after the last rvalid.
- `fill_req` held high 5 cycles past the stream end → no second `mem_req` until `fill_req` has been low for at least one cycle.
- `reset_n`=0 during COLLECT after 2 words, then 2 stray `mem_rvalid`s → `mem_req`=0 and `fill_strobe` stays 0; a following request fetches and streams correctly.
- `fill_req` dropped during COLLECT → all 4 words are absorbed, no strobe, return to IDLE.
- With `LINE_REUSE_EN`: repeat request to 0x000408 → strobe 2 cycles after the request with no `mem_req`. Then `snoop_we` to 0x00040A followed by a request to the same line → `mem_req` is issued.
